// File: rtl/ppl_dispatch.sv
// Ray dispatcher for the raymarch stepping pipeline: issues new rays, catches
// returns PPL_LAT cycles later, recirculates unfinished rays, queues finished
// pixels in a fall-through FIFO, and sequences each frame (start/drain/done).
module ppl_dispatch #(
  parameter int          PPL_LAT    = 6,
  parameter int          MAX_STEPS  = 24,
  parameter logic [12:0] SKY_TEX    = 13'h1F00,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        frame_done,
  input  logic        gen_valid,
  output logic        gen_ready,
  input  logic        gen_last,
  input  logic [15:0] gen_pos_x,
  input  logic [15:0] gen_pos_y,
  input  logic [15:0] gen_pos_z,
  input  logic [15:0] gen_slope_x,
  input  logic [15:0] gen_slope_y,
  input  logic [15:0] gen_slope_z,
  input  logic [19:0] gen_pixel_addr,
  output logic        prepare_flag,
  output logic        iss_valid,
  output logic [15:0] iss_pos_x,
  output logic [15:0] iss_pos_y,
  output logic [15:0] iss_pos_z,
  output logic [15:0] iss_slope_x,
  output logic [15:0] iss_slope_y,
  output logic [15:0] iss_slope_z,
  output logic [19:0] iss_pixel_addr,
  output logic [4:0]  iss_block_cnt,
  input  logic [15:0] ret_end_pos_x,
  input  logic [15:0] ret_end_pos_y,
  input  logic [15:0] ret_end_pos_z,
  input  logic [15:0] ret_slope_x,
  input  logic [15:0] ret_slope_y,
  input  logic [15:0] ret_slope_z,
  input  logic [19:0] ret_pixel_addr,
  input  logic [4:0]  ret_block_cnt,
  input  logic        ret_next_en,
  input  logic [12:0] ret_texture_addr,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [19:0] pix_addr,
  output logic [12:0] pix_tex_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [4:0]    MAX_STEPS_W = 5'(MAX_STEPS);
  localparam logic [SW-1:0] DEPTH_W     = SW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PPL_LAT-1:0] r_live_sr;
  logic [CW-1:0]      r_live_cnt;
  logic [CW-1:0]      r_fifo_cnt;
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [32:0]        r_fifo_mem [FIFO_DEPTH];

  logic        r_iss_valid;
  logic [15:0] r_iss_pos_x, r_iss_pos_y, r_iss_pos_z;
  logic [15:0] r_iss_slope_x, r_iss_slope_y, r_iss_slope_z;
  logic [19:0] r_iss_pixel_addr;
  logic [4:0]  r_iss_block_cnt;

  logic          w_ret_live, w_push, w_recirc, w_accept, w_pop;
  logic          w_credit_ok, w_frame_done;
  logic [SW-1:0] w_occ;
  logic [12:0]   w_push_tex;

  // Return decision: a hit wins over the step limit; anything else goes round again.
  assign w_ret_live  = r_live_sr[PPL_LAT-1];
  assign w_push      = w_ret_live & (ret_next_en | (ret_block_cnt >= MAX_STEPS_W));
  assign w_recirc    = w_ret_live & ~w_push;
  assign w_push_tex  = ret_next_en ? ret_texture_addr : SKY_TEX;

  // Every in-flight ray owns a FIFO slot, so pushes can never overflow.
  assign w_occ       = SW'(r_fifo_cnt) + SW'(r_live_cnt);
  assign w_credit_ok = (w_occ < DEPTH_W);
  assign gen_ready   = (r_state == S_RUN) & ~w_recirc & w_credit_ok;
  assign w_accept    = gen_valid & gen_ready;
  assign w_pop       = pix_valid & pix_ready;

  assign prepare_flag = (r_state == S_IDLE);
  assign frame_done   = w_frame_done;
  assign pix_valid    = (r_fifo_cnt != '0);
  assign {pix_addr, pix_tex_addr} = r_fifo_mem[r_rd_ptr];

  assign iss_valid      = r_iss_valid;
  assign iss_pos_x      = r_iss_pos_x;
  assign iss_pos_y      = r_iss_pos_y;
  assign iss_pos_z      = r_iss_pos_z;
  assign iss_slope_x    = r_iss_slope_x;
  assign iss_slope_y    = r_iss_slope_y;
  assign iss_slope_z    = r_iss_slope_z;
  assign iss_pixel_addr = r_iss_pixel_addr;
  assign iss_block_cnt  = r_iss_block_cnt;

  // Frame state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Frame sequencing: start, stop accepting after the last ray, finish when empty.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:  if (frame_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && gen_last) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (r_live_cnt == '0 && r_fifo_cnt == '0) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Issue slot: recirculation has priority, then a new ray, else the slot idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid      <= 1'b0;
      r_iss_pos_x      <= '0;
      r_iss_pos_y      <= '0;
      r_iss_pos_z      <= '0;
      r_iss_slope_x    <= '0;
      r_iss_slope_y    <= '0;
      r_iss_slope_z    <= '0;
      r_iss_pixel_addr <= '0;
      r_iss_block_cnt  <= '0;
    end else if (w_recirc) begin
      r_iss_valid      <= 1'b1;
      r_iss_pos_x      <= ret_end_pos_x;
      r_iss_pos_y      <= ret_end_pos_y;
      r_iss_pos_z      <= ret_end_pos_z;
      r_iss_slope_x    <= ret_slope_x;
      r_iss_slope_y    <= ret_slope_y;
      r_iss_slope_z    <= ret_slope_z;
      r_iss_pixel_addr <= ret_pixel_addr;
      r_iss_block_cnt  <= ret_block_cnt;
    end else if (w_accept) begin
      r_iss_valid      <= 1'b1;
      r_iss_pos_x      <= gen_pos_x;
      r_iss_pos_y      <= gen_pos_y;
      r_iss_pos_z      <= gen_pos_z;
      r_iss_slope_x    <= gen_slope_x;
      r_iss_slope_y    <= gen_slope_y;
      r_iss_slope_z    <= gen_slope_z;
      r_iss_pixel_addr <= gen_pixel_addr;
      r_iss_block_cnt  <= '0;
    end else begin
      r_iss_valid      <= 1'b0;
    end
  end

  // Track which pipeline slots hold live rays and how many rays are in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live_sr  <= '0;
      r_live_cnt <= '0;
    end else begin
      r_live_sr <= {r_live_sr[PPL_LAT-2:0], r_iss_valid};
      case ({w_accept, w_push})
        2'b10:   r_live_cnt <= r_live_cnt + CW'(1);
        2'b01:   r_live_cnt <= r_live_cnt - CW'(1);
        default: r_live_cnt <= r_live_cnt;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle are both honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FIFO storage for {pixel address, texture address}.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the occupancy count alone decides validity.
    if (w_push) r_fifo_mem[r_wr_ptr] <= {ret_pixel_addr, w_push_tex};
  end

endmodule

// File: tb/tb_ppl_dispatch.sv
// Bench for ppl_dispatch: models the stepping pipeline as a PPL_LAT delay line,
// predicts FIFO pushes into a scoreboard queue and checks pops in order.
module tb_ppl_dispatch;

  localparam int          LAT = 6;
  localparam logic [12:0] SKY = 13'h1F00;

  logic        clk, rst, frame_start, gen_valid, gen_last, pix_ready;
  logic [15:0] gen_pos_x, gen_pos_y, gen_pos_z, gen_slope_x, gen_slope_y, gen_slope_z;
  logic [19:0] gen_pixel_addr;
  logic [15:0] ret_end_pos_x, ret_end_pos_y, ret_end_pos_z;
  logic [15:0] ret_slope_x, ret_slope_y, ret_slope_z;
  logic [19:0] ret_pixel_addr;
  logic [4:0]  ret_block_cnt;
  logic        ret_next_en;
  logic [12:0] ret_texture_addr;
  logic        frame_done, gen_ready, prepare_flag, iss_valid, pix_valid;
  logic [15:0] iss_pos_x, iss_pos_y, iss_pos_z, iss_slope_x, iss_slope_y, iss_slope_z;
  logic [19:0] iss_pixel_addr, pix_addr;
  logic [4:0]  iss_block_cnt;
  logic [12:0] pix_tex_addr;

  ppl_dispatch dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_done(frame_done),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_last(gen_last),
    .gen_pos_x(gen_pos_x), .gen_pos_y(gen_pos_y), .gen_pos_z(gen_pos_z),
    .gen_slope_x(gen_slope_x), .gen_slope_y(gen_slope_y), .gen_slope_z(gen_slope_z),
    .gen_pixel_addr(gen_pixel_addr), .prepare_flag(prepare_flag), .iss_valid(iss_valid),
    .iss_pos_x(iss_pos_x), .iss_pos_y(iss_pos_y), .iss_pos_z(iss_pos_z),
    .iss_slope_x(iss_slope_x), .iss_slope_y(iss_slope_y), .iss_slope_z(iss_slope_z),
    .iss_pixel_addr(iss_pixel_addr), .iss_block_cnt(iss_block_cnt),
    .ret_end_pos_x(ret_end_pos_x), .ret_end_pos_y(ret_end_pos_y), .ret_end_pos_z(ret_end_pos_z),
    .ret_slope_x(ret_slope_x), .ret_slope_y(ret_slope_y), .ret_slope_z(ret_slope_z),
    .ret_pixel_addr(ret_pixel_addr), .ret_block_cnt(ret_block_cnt), .ret_next_en(ret_next_en),
    .ret_texture_addr(ret_texture_addr), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_tex_addr(pix_tex_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        stale;
    logic [15:0] px, py, pz, sx, sy, sz;
    logic [19:0] pix;
    logic [4:0]  blk;
  } snap_t;

  typedef struct packed {
    logic fs, gv, gl, pr;
    logic prep, rdy, iss, pv, done;
  } vec_t;

  snap_t       hist[$];
  snap_t       cur;
  logic [32:0] exp_q[$];
  int          hit_at[int];
  logic [12:0] tex_of[int];
  int          n_vec, n_bad, n_acc;
  vec_t        vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pipeline model: end = start + slope, block count +1, hit decided per pixel.
  task automatic drive_ret(input snap_t e);
    int h;
    if (e.v) begin
      ret_end_pos_x  = e.px + e.sx;
      ret_end_pos_y  = e.py + e.sy;
      ret_end_pos_z  = e.pz + e.sz;
      ret_slope_x    = e.sx;
      ret_slope_y    = e.sy;
      ret_slope_z    = e.sz;
      ret_pixel_addr = e.pix;
      ret_block_cnt  = e.blk + 5'd1;
      h = hit_at.exists(int'(e.pix)) ? hit_at[int'(e.pix)] : 1;
      ret_next_en = (h != 0) && (int'(ret_block_cnt) == h);
      ret_texture_addr = tex_of.exists(int'(e.pix)) ? tex_of[int'(e.pix)]
                                                    : (e.pix[12:0] ^ 13'h0AAA);
    end else begin
      ret_end_pos_x    = 16'($urandom);
      ret_end_pos_y    = 16'($urandom);
      ret_end_pos_z    = 16'($urandom);
      ret_slope_x      = 16'($urandom);
      ret_slope_y      = 16'($urandom);
      ret_slope_z      = 16'($urandom);
      ret_pixel_addr   = 20'($urandom);
      ret_block_cnt    = 5'($urandom);
      ret_next_en      = 1'($urandom);
      ret_texture_addr = 13'($urandom);
    end
  endtask

  // One clock: score at the falling edge, then present the next pipeline return.
  task automatic step();
    snap_t s;
    logic [32:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      foreach (hist[i]) hist[i].stale = 1'b1;
    end else begin
      if (gen_valid && gen_ready) n_acc++;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 64'({pix_addr, pix_tex_addr}), 64'h1_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pix_out", 64'({pix_addr, pix_tex_addr}), 64'(e));
        end
      end
      if (cur.v && !cur.stale) begin
        if (ret_next_en)              exp_q.push_back({ret_pixel_addr, ret_texture_addr});
        else if (ret_block_cnt >= 24) exp_q.push_back({ret_pixel_addr, SKY});
      end
    end
    s = '{v: iss_valid, stale: rst, px: iss_pos_x, py: iss_pos_y, pz: iss_pos_z,
          sx: iss_slope_x, sy: iss_slope_y, sz: iss_slope_z, pix: iss_pixel_addr,
          blk: iss_block_cnt};
    hist.push_back(s);
    @(posedge clk);
    #1;
    cur = hist.pop_front();
    drive_ret(cur);
    #1;
  endtask

  task automatic set_gen(input logic [19:0] pix, input logic [15:0] px, input logic [15:0] sx);
    gen_pixel_addr = pix;
    gen_pos_x = px;   gen_pos_y = 16'($urandom); gen_pos_z = 16'($urandom);
    gen_slope_x = sx; gen_slope_y = 16'($urandom); gen_slope_z = 16'($urandom);
  endtask

  task automatic wait_accept(input string name);
    int a0;
    a0 = n_acc;
    gen_valid = 1'b1;
    for (int i = 0; i < 40 && n_acc == a0; i++) step();
    gen_valid = 1'b0;
    gen_last  = 1'b0;
    check(name, 64'(n_acc - a0), 64'd1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && !frame_done; i++) step();
    check(name, 64'(frame_done), 64'd1);
    step();
    check({name, "_idle"}, 64'(prepare_flag), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    snap_t z;
    n_vec = 0; n_bad = 0; n_acc = 0;
    z = '0;
    cur = z;
    for (int i = 0; i < LAT - 1; i++) hist.push_back(z);
    rst = 1'b1; frame_start = 1'b0; gen_valid = 1'b0; gen_last = 1'b0; pix_ready = 1'b0;
    set_gen(20'h0, 16'h0, 16'h0);
    drive_ret(z);
    hit_at[32'h00123] = 1;  tex_of[32'h00123] = 13'h0105;
    hit_at[32'h00200] = 4;  tex_of[32'h00200] = 13'h0222;
    hit_at[32'h00300] = 0;
    hit_at[32'h00400] = 24; tex_of[32'h00400] = 13'h0444;

    // Reset values.
    step();
    check("rst_prepare", 64'(prepare_flag), 64'd1);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_gen_ready", 64'(gen_ready), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_iss_data", 64'({iss_pos_x, iss_pixel_addr, iss_block_cnt}), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Single ray, cycle by cycle: {fs,gv,gl,pr} -> {prep,rdy,iss,pv,done}.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // gen ignored in IDLE
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // accept last ray
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // start ignored
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // return, push
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // head held
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // pop
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // frame_done
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    set_gen(20'h00123, 16'h0100, 16'h0010);
    foreach (vecs[i]) begin
      frame_start = vecs[i].fs; gen_valid = vecs[i].gv;
      gen_last = vecs[i].gl;    pix_ready = vecs[i].pr;
      #1;
      check($sformatf("v%0d_prepare", i), 64'(prepare_flag), 64'(vecs[i].prep));
      check($sformatf("v%0d_gen_ready", i), 64'(gen_ready), 64'(vecs[i].rdy));
      check($sformatf("v%0d_iss_valid", i), 64'(iss_valid), 64'(vecs[i].iss));
      check($sformatf("v%0d_pix_valid", i), 64'(pix_valid), 64'(vecs[i].pv));
      check($sformatf("v%0d_frame_done", i), 64'(frame_done), 64'(vecs[i].done));
      step();
    end
    frame_start = 1'b0; gen_valid = 1'b0; gen_last = 1'b0;

    // Recirculation, step limit and hit-beats-limit priority in one frame.
    pix_ready = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    set_gen(20'h00200, 16'h0500, 16'h0100);
    wait_accept("recirc_accept");
    check("free_slot_ready", 64'(gen_ready), 64'd1);
    for (int i = 0; i < 60; i++) begin
      if (cur.v && cur.pix == 20'h00200 && ret_block_cnt == 5'd3) break;
      step();
    end
    check("recirc_ret_seen", 64'(ret_block_cnt), 64'd3);
    check("recirc_gen_ready", 64'(gen_ready), 64'd0);
    step();
    check("recirc_iss_valid", 64'(iss_valid), 64'd1);
    check("recirc_iss_pos_x", 64'(iss_pos_x), 64'h0800);
    check("recirc_iss_blk", 64'(iss_block_cnt), 64'd3);
    check("recirc_iss_pix", 64'(iss_pixel_addr), 64'h00200);

    set_gen(20'h00300, 16'h1000, 16'h0004);
    wait_accept("limit_accept");
    for (int i = 0; i < 300; i++) begin
      if (cur.v && cur.pix == 20'h00300 && ret_block_cnt == 5'd24) break;
      step();
    end
    check("limit_ret_seen", 64'(ret_block_cnt), 64'd24);
    check("limit_gen_ready", 64'(gen_ready), 64'd1);
    step();
    check("limit_no_reissue", 64'(iss_valid), 64'd0);

    set_gen(20'h00400, 16'h2000, 16'h0002);
    gen_last = 1'b1;
    wait_accept("prio_accept");
    wait_done("frame2_done");

    // Credit backpressure: reader stalled, generator always valid.
    pix_ready = 1'b0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    a0 = n_acc;
    gen_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      set_gen(20'h10000 + 20'(n_acc - a0), 16'(i), 16'h0001);
      step();
    end
    check("credit_accepts", 64'(n_acc - a0), 64'd16);
    check("credit_gen_ready", 64'(gen_ready), 64'd0);
    check("credit_pix_valid", 64'(pix_valid), 64'd1);
    // Release the reader and keep streaming: pushes and pops overlap across wrap.
    pix_ready = 1'b1;
    for (int i = 0; i < 400 && (n_acc - a0) < 40; i++) begin
      set_gen(20'h10000 + 20'(n_acc - a0), 16'(i), 16'h0001);
      gen_last = ((n_acc - a0) == 39);
      step();
    end
    gen_valid = 1'b0; gen_last = 1'b0;
    check("stream_accepts", 64'(n_acc - a0), 64'd40);
    wait_done("frame3_done");

    // Reset mid-frame with rays both in flight and queued.
    pix_ready = 1'b0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    a0 = n_acc;
    gen_valid = 1'b1;
    for (int i = 0; i < 30 && (n_acc - a0) < 7; i++) begin
      set_gen(20'h20000 + 20'(n_acc - a0), 16'h0040, 16'h0001);
      step();
    end
    gen_valid = 1'b0;
    check("mid_accepts", 64'(n_acc - a0), 64'd7);
    for (int i = 0; i < 30 && exp_q.size() < 3; i++) step();
    check("mid_queued", 64'(exp_q.size()), 64'd3);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_prepare", 64'(prepare_flag), 64'd1);
    check("mid_rst_pix_valid", 64'(pix_valid), 64'd0);
    check("mid_rst_iss_valid", 64'(iss_valid), 64'd0);
    pix_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("stale_%0d_pix_valid", i), 64'(pix_valid), 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
